data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-port, round-robin access controller in front of the single-ported `data_memory`. It serialises load/store requests from port 0 (CPU load/store unit) and port 1 (DMA/debug loader) onto one memory interface. It asserts the memory's level-sensitive `write` for exactly one cycle per store. It returns read data and the memory's address-range exception to the owning requester.

## Interface
- `DATA_ADDR_WIDTH`, 16, address width on both requester ports and the memory side.
- `DATA_WIDTH`, 16, data word width.
- `ERR_CNT_WIDTH`, 8, width of the saturating exception counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0` / `req1`  in  1  access request, held high until the matching grant is seen.
- `we0` / `we1`  in  1  1 = store, 0 = load; stable while the request is high.
- `addr0` / `addr1`  in  DATA_ADDR_WIDTH  word address.
- `wdata0` / `wdata1`  in  DATA_WIDTH  store data.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: request latched, memory access in progress.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse: access complete, `rdata`/`err` valid.
- `rdata0` / `rdata1`  out  DATA_WIDTH  load data; holds its value between responses.
- `err0` / `err1`  out  1  qualified by `rvalid`: the access hit the memory exception.
- `mem_addr`  out  DATA_ADDR_WIDTH  to memory `addr`.
- `mem_data_in`  out  DATA_WIDTH  to memory `data_in`.
- `mem_write`  out  1  to memory `write`.
- `mem_data_out`  in  DATA_WIDTH  from memory `data_out`.
- `mem_exception`  in  1  from memory `exception`.
- `err_count`  out  ERR_CNT_WIDTH  saturating count of excepted accesses.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Arbitration runs only in IDLE and RESP.
- IDLE: if any request is high, latch the winner's `we`/`addr`/`wdata` and owner ID, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS:
  - Drive the latched fields onto the memory interface.
  - Assert `gnt` of the owner.
  - Assert `mem_write` = latched `we`.
  - At the edge, capture `mem_data_out` into the owner's `rdata` (loads only; stores leave `rdata` unchanged) and capture `mem_exception`. Go to RESP.
- RESP:
  - Assert the owner's `rvalid`, plus `err` when the captured exception is set.
  - If a request is pending, arbitrate and go straight to ACCESS; otherwise go to IDLE.
- Round-robin:
  - Both requesting: the port not granted last wins.
  - One requesting: that port wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- `mem_write` is high only in ACCESS with latched `we` = 1. It is never high in IDLE or RESP. An out-of-range store therefore never writes, and the memory raises its exception.
- `mem_addr`/`mem_data_in` hold their last latched value outside ACCESS.
- `err_count` increments by 1 on each RESP whose captured exception is set, and saturates at all-ones.
- A requester must drop or change `req` no later than the edge after it sees `gnt`. A request still high during RESP is treated as a new request.

## Timing
- Reset values: state IDLE; every `gnt`, `rvalid`, `err`, and `mem_write` = 0; `rdata0`/`rdata1`, `mem_addr`, `mem_data_in`, `err_count` = 0; `last_grant` = 1.
- Single access:
  - `req` first sampled high at edge E.
  - `gnt` high in cycle E..E+1.
  - `rvalid` high in cycle E+1..E+2.
  - Load-to-data latency: 2 cycles.
- Back-to-back throughput: one access every 2 cycles (RESP overlaps the next arbitration).
- Simultaneous requests at IDLE: the winner is served first; the loser keeps `req` high and is granted from RESP with no idle cycle.
- Reset asserted mid-access: the FSM goes to IDLE immediately. `mem_write` drops asynchronously, and the in-flight transaction is dropped with no `rvalid`.

## Structure
- Shared package `dmem_arb_pkg`:
  - state encoding constants (IDLE, ACCESS, RESP);
  - default `DATA_ADDR_WIDTH`/`DATA_WIDTH`;
  - port ID constants (PORT_CPU = 0, PORT_DMA = 1).
- One sub-module, `rr_arbiter_2`, is natural. It is combinational: inputs `req0`, `req1`, `last_grant`; outputs `valid` and `winner`. The FSM, hold registers and counter stay in `data_memory_arbiter`.

## Test plan
- Port 0 store addr 0x0005 data 0xBEEF, then port 0 load 0x0005 -> `mem_write` high exactly 1 cycle; `rvalid0` 2 cycles after request; `rdata0` = 0xBEEF; `err0` = 0.
- `req0` and `req1` both high from reset, loads at 0x0001 and 0x0002 -> `gnt0` first, `gnt1` 2 cycles later; both `rvalid`s with correct data; no dead cycle between accesses.
- Both ports held requesting continuously for 8 accesses -> grants alternate 0,1,0,1…; neither port starved.
- Port 1 store to 0x0400 (= DATA_SIZE 1024) -> `rvalid1` with `err1` = 1; `err_count` = 1; a following load at 0x03FF returns the prior contents unchanged.
- 300 out-of-range loads -> `err_count` saturates at 0xFF.
- `rst_n` pulled low during ACCESS of a store -> `mem_write` drops immediately; no `rvalid`; all outputs at reset values; the next request is served normally.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_DATA_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH      = 16;
  localparam int unsigned DEF_ERR_CNT_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: on a tie the port that did not win last time wins.
module rr_arbiter_2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Serialises two requester ports onto the single-ported data memory with
// round-robin arbitration and a one-cycle write strobe per store.
module data_memory_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_ADDR_WIDTH = DEF_DATA_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned ERR_CNT_WIDTH   = DEF_ERR_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0,
  input  logic                       req1,
  input  logic                       we0,
  input  logic                       we1,
  input  logic [DATA_ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]      wdata0,
  input  logic [DATA_WIDTH-1:0]      wdata1,
  output logic                       gnt0,
  output logic                       gnt1,
  output logic                       rvalid0,
  output logic                       rvalid1,
  output logic [DATA_WIDTH-1:0]      rdata0,
  output logic [DATA_WIDTH-1:0]      rdata1,
  output logic                       err0,
  output logic                       err1,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data_in,
  output logic                       mem_write,
  input  logic [DATA_WIDTH-1:0]      mem_data_out,
  input  logic                       mem_exception,
  output logic [ERR_CNT_WIDTH-1:0]   err_count
);

  state_e                     state_q, state_d;
  logic                       owner_q, owner_d;
  logic                       last_grant_q, last_grant_d;
  logic                       we_q, we_d;
  logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]      rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]      rdata1_q, rdata1_d;
  logic [ERR_CNT_WIDTH-1:0]   err_count_q, err_count_d;
  logic                       gnt0_q, gnt0_d;
  logic                       gnt1_q, gnt1_d;
  logic                       rvalid0_q, rvalid0_d;
  logic                       rvalid1_q, rvalid1_d;
  logic                       err0_q, err0_d;
  logic                       err1_q, err1_d;
  logic                       mem_write_q, mem_write_d;

  logic arb_valid;
  logic arb_winner;
  logic grant_ok;

  rr_arbiter_2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    err_count_d  = err_count_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    mem_write_d  = 1'b0;
    grant_ok     = 1'b0;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d  = ST_IDLE;
        grant_ok = arb_valid;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (owner_q == PORT_DMA) begin
          rvalid1_d = 1'b1;
          err1_d    = mem_exception;
          if (!we_q) rdata1_d = mem_data_out;
        end else begin
          rvalid0_d = 1'b1;
          err0_d    = mem_exception;
          if (!we_q) rdata0_d = mem_data_out;
        end
        if (mem_exception && (err_count_q != '1)) begin
          err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // RESP overlaps the next arbitration so back-to-back accesses have no gap.
    if (grant_ok) begin
      state_d      = ST_ACCESS;
      owner_d      = arb_winner;
      last_grant_d = arb_winner;
      if (arb_winner == PORT_DMA) begin
        we_d    = we1;
        addr_d  = addr1;
        wdata_d = wdata1;
        gnt1_d  = 1'b1;
      end else begin
        we_d    = we0;
        addr_d  = addr0;
        wdata_d = wdata0;
        gnt0_d  = 1'b1;
      end
      mem_write_d = we_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_CPU;
      last_grant_q <= PORT_DMA;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      err_count_q  <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      err_count_q  <= err_count_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign err0        = err0_q;
  assign err1        = err1_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_write   = mem_write_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomised and directed bench for data_memory_arbiter against a
// transaction-level reference model and a behavioural 1024-word memory.
module tb_data_memory_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned AW        = 16;
  localparam int unsigned DW        = 16;
  localparam int unsigned CW        = 8;
  localparam int unsigned DATA_SIZE = 1024;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk;
  logic rst_n;
  logic [1:0]         req_v, we_v;
  logic [1:0][AW-1:0] addr_v;
  logic [1:0][DW-1:0] wdata_v;
  logic gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic mem_write, mem_exception;
  logic [CW-1:0] err_count;
  logic [1:0] gnt_v, rvalid_v, err_v;

  assign gnt_v    = {gnt1, gnt0};
  assign rvalid_v = {rvalid1, rvalid0};
  assign err_v    = {err1, err0};

  data_memory_arbiter #(
    .DATA_ADDR_WIDTH (AW),
    .DATA_WIDTH      (DW),
    .ERR_CNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0          (req_v[0]),
    .req1          (req_v[1]),
    .we0           (we_v[0]),
    .we1           (we_v[1]),
    .addr0         (addr_v[0]),
    .addr1         (addr_v[1]),
    .wdata0        (wdata_v[0]),
    .wdata1        (wdata_v[1]),
    .gnt0          (gnt0),
    .gnt1          (gnt1),
    .rvalid0       (rvalid0),
    .rvalid1       (rvalid1),
    .rdata0        (rdata0),
    .rdata1        (rdata1),
    .err0          (err0),
    .err1          (err1),
    .mem_addr      (mem_addr),
    .mem_data_in   (mem_data_in),
    .mem_write     (mem_write),
    .mem_data_out  (mem_data_out),
    .mem_exception (mem_exception),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int unsigned i);
    return DW'(i * 257 + 3840);
  endfunction

  function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // Behavioural data memory: async read, write on the clock edge, exception when out of range.
  logic [DW-1:0] mem [DATA_SIZE];
  bit mem_ready = 1'b0;
  assign mem_exception = (mem_addr >= AW'(DATA_SIZE));
  assign mem_data_out  = mem_exception ? '0 : mem[mem_addr[9:0]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < int'(DATA_SIZE); i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_write && !mem_exception) begin
      mem[mem_addr[9:0]] <= mem_data_in;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Requester driver: each port presents the head of its queue until granted.
  txn_t q0[$], q1[$];
  bit gap_en = 1'b0;

  task automatic drive_port(input int p);
    bit   fresh;
    txn_t t;
    fresh = (req_v[p] == 1'b0);
    if (gnt_v[p]) begin
      if (p == 0 && q0.size() > 0) q0.delete(0);
      if (p == 1 && q1.size() > 0) q1.delete(0);
      fresh = 1'b1;
    end
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      req_v[p] = 1'b0;
    end else if (fresh) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        req_v[p] = 1'b0;
      end else begin
        t = (p == 0) ? q0[0] : q1[0];
        req_v[p]   = 1'b1;
        we_v[p]    = t.we;
        addr_v[p]  = t.addr;
        wdata_v[p] = t.wdata;
      end
    end
  endtask

  initial begin : driver
    req_v = '0; we_v = '0; addr_v = '0; wdata_v = '0;
    forever begin
      @(posedge clk);
      #1;
      drive_port(0);
      drive_port(1);
    end
  end

  // Reference model: an access may start on any edge except the one right
  // after a grant; its response appears one cycle after the grant.
  logic [DW-1:0] ref_mem [DATA_SIZE];
  logic [1:0]    e_gnt, e_rvalid, e_err;
  logic [DW-1:0] e_rdata [2];
  logic          e_mw;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic [CW-1:0] e_cnt;
  int   last_grant, cur_port, cyc, mw_cycles;
  bit   busy, pend_valid;
  txn_t cur;
  logic [9:0]    pend_addr;
  logic [DW-1:0] pend_data;
  int   grant_log[$], grant_cyc[$];

  task automatic reset_model();
    e_gnt = '0; e_rvalid = '0; e_err = '0; e_mw = 1'b0;
    e_rdata[0] = '0; e_rdata[1] = '0;
    e_addr = '0; e_din = '0; e_cnt = '0;
    last_grant = 1; busy = 1'b0; pend_valid = 1'b0;
  endtask

  task automatic advance();
    int w;
    bit oob;
    e_gnt = '0; e_rvalid = '0; e_err = '0; e_mw = 1'b0;
    if (busy) begin
      oob = (cur.addr >= AW'(DATA_SIZE));
      e_rvalid[cur_port] = 1'b1;
      e_err[cur_port]    = oob;
      if (oob && e_cnt != '1) e_cnt = e_cnt + CW'(1);
      if (!cur.we) e_rdata[cur_port] = oob ? '0 : ref_mem[cur.addr[9:0]];
      else if (!oob) begin
        pend_valid = 1'b1; pend_addr = cur.addr[9:0]; pend_data = cur.wdata;
      end
      busy = 1'b0;
    end else if (req_v != 2'b00) begin
      if (req_v == 2'b11) w = 1 - last_grant;
      else w = req_v[1] ? 1 : 0;
      cur.we = we_v[w]; cur.addr = addr_v[w]; cur.wdata = wdata_v[w];
      cur_port = w; last_grant = w; busy = 1'b1;
      e_gnt[w] = 1'b1; e_mw = cur.we; e_addr = cur.addr; e_din = cur.wdata;
    end
  endtask

  task automatic check_outputs();
    cmp("gnt", 32'(gnt_v), 32'(e_gnt));
    cmp("rvalid", 32'(rvalid_v), 32'(e_rvalid));
    for (int p = 0; p < 2; p++) if (e_rvalid[p]) cmp("err", 32'(err_v[p]), 32'(e_err[p]));
    cmp("rdata0", 32'(rdata0), 32'(e_rdata[0]));
    cmp("rdata1", 32'(rdata1), 32'(e_rdata[1]));
    cmp("mem_write", 32'(mem_write), 32'(e_mw));
    cmp("mem_addr", 32'(mem_addr), 32'(e_addr));
    cmp("mem_data_in", 32'(mem_data_in), 32'(e_din));
    cmp("err_count", 32'(err_count), 32'(e_cnt));
  endtask

  initial begin : model
    for (int i = 0; i < int'(DATA_SIZE); i++) ref_mem[i] = init_val(i);
    cyc = 0; mw_cycles = 0;
    reset_model();
    forever begin
      @(negedge clk);
      cyc++;
      if (pend_valid) begin
        if (rst_n) ref_mem[pend_addr] = pend_data;
        pend_valid = 1'b0;
      end
      if (!rst_n) reset_model();
      if (mem_write) mw_cycles++;
      if (gnt0) begin grant_log.push_back(0); grant_cyc.push_back(cyc); end
      if (gnt1) begin grant_log.push_back(1); grant_cyc.push_back(cyc); end
      check_outputs();
      if (rst_n) advance();
    end
  end

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    cmp("drain_in_time", 32'(n < max_cyc), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin : main
    bit found;
    rst_n = 1'b0;

    // Both ports requesting straight out of reset: port 0 wins the first tie.
    q0.push_back(mk(1'b0, 16'h0001, 16'h0));
    q1.push_back(mk(1'b0, 16'h0002, 16'h0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drain(20);
    cmp("tie_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      cmp("tie_first_port", 32'(grant_log[0]), 32'd0);
      cmp("tie_grant_spacing", 32'(grant_cyc[1] - grant_cyc[0]), 32'd2);
    end
    cmp("tie_rdata0", 32'(rdata0), 32'(init_val(1)));
    cmp("tie_rdata1", 32'(rdata1), 32'(init_val(2)));

    // Store then load on port 0.
    mw_cycles = 0;
    q0.push_back(mk(1'b1, 16'h0005, 16'hBEEF));
    drain(20);
    cmp("store_write_cycles", 32'(mw_cycles), 32'd1);
    q0.push_back(mk(1'b0, 16'h0005, 16'h0));
    drain(20);
    cmp("load_back_rdata0", 32'(rdata0), 32'h0000BEEF);

    // Continuous contention alternates grants.
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 16'($urandom_range(0, 1023)), 16'h0));
      q1.push_back(mk(1'b0, 16'($urandom_range(0, 1023)), 16'h0));
    end
    drain(40);
    cmp("rr_grant_count", 32'(grant_log.size()), 32'd8);
    if (grant_log.size() == 8) begin
      cmp("rr_first_port", 32'(grant_log[0]), 32'd1);
      for (int i = 1; i < 8; i++) cmp("rr_alternate", 32'(grant_log[i] != grant_log[i-1]), 32'd1);
    end

    // Out-of-range store raises the exception and writes nothing.
    q0.push_back(mk(1'b1, 16'h03FF, 16'h1234));
    drain(20);
    q1.push_back(mk(1'b1, 16'h0400, 16'h5555));
    drain(20);
    cmp("oor_store_count", 32'(err_count), 32'd1);
    q1.push_back(mk(1'b0, 16'h03FF, 16'h0));
    q0.push_back(mk(1'b0, 16'h0000, 16'h0));
    drain(20);
    cmp("after_oor_rdata1", 32'(rdata1), 32'h00001234);
    cmp("no_alias_rdata0", 32'(rdata0), 32'(init_val(0)));

    // Saturation of the exception counter.
    for (int i = 0; i < 300; i++) q1.push_back(mk(1'b0, 16'(16'h0400 + $urandom_range(0, 16'hFBFF)), 16'h0));
    drain(800);
    cmp("err_count_saturated", 32'(err_count), 32'h000000FF);

    // Reset in the middle of a store access.
    q0.push_back(mk(1'b1, 16'h0010, 16'hAAAA));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_write) found = 1'b1;
    end
    cmp("store_reached_access", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    cmp("rst_mem_write", 32'(mem_write), 32'd0);
    cmp("rst_gnt", 32'(gnt_v), 32'd0);
    cmp("rst_err_count", 32'(err_count), 32'd0);
    cmp("rst_mem_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q0.push_back(mk(1'b0, 16'h0010, 16'h0));
    drain(20);
    cmp("dropped_store_rdata0", 32'(rdata0), 32'(init_val(16)));

    // Random mixed traffic with request gaps.
    gap_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      txn_t t;
      logic [AW-1:0] a;
      if ($urandom_range(0, 3) == 0) a = AW'(1008 + $urandom_range(0, 31));
      else a = AW'($urandom_range(0, 15));
      t = mk(1'($urandom_range(0, 1)), a, DW'($urandom));
      if ($urandom_range(0, 1) == 0) q0.push_back(t);
      else q1.push_back(t);
    end
    drain(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
